// File: rtl/motion_estimator.sv
// motion_estimator: full-search integer motion estimation over a square window.
// Loads one MACRO_DIM x MACRO_DIM current block, then walks every candidate
// offset two columns at a time: lane A at dx, lane B at dx+1.
// Reports the minimum SAD.
// Optional feature macro ME_MV_OUT_EN adds the mv_x/mv_y outputs, which carry
// the offset of the winning candidate.
module motion_estimator #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  pixel_cpr_in [0:MACRO_DIM-1],
    input  logic [7:0]  pixel_spr_in [0:MACRO_DIM],
    output logic        ready,
    output logic        valid,
    output logic [5:0]  addr,
    output logic [5:0]  amt,
    output logic [15:0] min_sad,
`ifdef ME_MV_OUT_EN
    output logic [5:0]  mv_x,
    output logic [5:0]  mv_y,
`endif
    output logic        done
);

    localparam int NPOS = SEARCH_DIM - MACRO_DIM + 1;
    localparam int RW   = $clog2(MACRO_DIM);
    localparam logic [6:0]    LAST_POS = 7'(NPOS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(MACRO_DIM - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SEARCH = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [5:0]    addr_q, addr_d;
    logic [5:0]    amt_q, amt_d;
    logic [RW-1:0] row_q, row_d;
    logic [5:0]    dx_q, dx_d;
    logic [5:0]    dy_q, dy_d;
    logic [15:0]   acc_a_q, acc_a_d;
    logic [15:0]   acc_b_q, acc_b_d;
    logic [15:0]   min_sad_q, min_sad_d;
    logic          valid_q, valid_d;
    logic [5:0]    mv_x_q, mv_x_d;
    logic [5:0]    mv_y_q, mv_y_d;

    logic [7:0]  cur_q [0:MACRO_DIM-1][0:MACRO_DIM-1];
    logic [15:0] sum_a, sum_b;
    logic [15:0] sad_a, sad_b;

    // Absolute difference through a 9-bit unsigned subtraction.
    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] d;
        logic [8:0] n;
        d = {1'b0, a} - {1'b0, b};
        n = -d;
        return d[8] ? n[7:0] : d[7:0];
    endfunction

    // Row SAD contributions of both lanes for the current block row.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
        sum_a = 16'd0;
        sum_b = 16'd0;
        for (int l = 0; l < MACRO_DIM; l++) begin
            sum_a = sum_a + {8'd0, abs_diff(cur_q[row_q][l], pixel_spr_in[l])};
            sum_b = sum_b + {8'd0, abs_diff(cur_q[row_q][l], pixel_spr_in[l+1])};
        end
        sad_a = acc_a_q + sum_a;
        sad_b = acc_b_q + sum_b;
    end

    // Next-state logic: load sequencing, candidate scan and minimum tracking.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        amt_d     = amt_q;
        row_d     = row_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        acc_a_d   = acc_a_q;
        acc_b_d   = acc_b_q;
        min_sad_d = min_sad_q;
        valid_d   = 1'b0;
        mv_x_d    = mv_x_q;
        mv_y_d    = mv_y_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    min_sad_d = 16'hFFFF;
                    mv_x_d    = 6'd0;
                    mv_y_d    = 6'd0;
                    addr_d    = 6'd0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (addr_q == 6'(MACRO_DIM - 1)) begin
                    addr_d  = 6'd0;
                    amt_d   = 6'd0;
                    row_d   = '0;
                    dx_d    = 6'd0;
                    dy_d    = 6'd0;
                    acc_a_d = 16'd0;
                    acc_b_d = 16'd0;
                    state_d = S_SEARCH;
                end else begin
                    addr_d = addr_q + 6'd1;
                end
            end
            S_SEARCH: begin
                if (row_q != LAST_ROW) begin
                    row_d   = row_q + 1'b1;
                    acc_a_d = sad_a;
                    acc_b_d = sad_b;
                    addr_d  = dy_q + 6'(row_q) + 6'd1;
                end else begin
                    // Strict-less compares keep the earliest candidate on ties.
                    if (sad_a < min_sad_d) begin
                        min_sad_d = sad_a;
                        mv_x_d    = dx_q;
                        mv_y_d    = dy_q;
                    end
                    // Lane B is off the window edge when dx is the last position.
                    if (({1'b0, dx_q} + 7'd1 <= LAST_POS) && (sad_b < min_sad_d)) begin
                        min_sad_d = sad_b;
                        mv_x_d    = dx_q + 6'd1;
                        mv_y_d    = dy_q;
                    end
                    acc_a_d = 16'd0;
                    acc_b_d = 16'd0;
                    row_d   = '0;
                    valid_d = 1'b1;
                    if ({1'b0, dx_q} + 7'd2 > LAST_POS) begin
                        dx_d = 6'd0;
                        if ({1'b0, dy_q} == LAST_POS) begin
                            state_d = S_DONE;
                        end else begin
                            dy_d   = dy_q + 6'd1;
                            addr_d = dy_q + 6'd1;
                            amt_d  = 6'd0;
                        end
                    end else begin
                        dx_d   = dx_q + 6'd2;
                        addr_d = dy_q;
                        amt_d  = dx_q + 6'd2;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= 6'd0;
            amt_q     <= 6'd0;
            row_q     <= '0;
            dx_q      <= 6'd0;
            dy_q      <= 6'd0;
            acc_a_q   <= 16'd0;
            acc_b_q   <= 16'd0;
            min_sad_q <= 16'hFFFF;
            valid_q   <= 1'b0;
            mv_x_q    <= 6'd0;
            mv_y_q    <= 6'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            amt_q     <= amt_d;
            row_q     <= row_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            acc_a_q   <= acc_a_d;
            acc_b_q   <= acc_b_d;
            min_sad_q <= min_sad_d;
            valid_q   <= valid_d;
            mv_x_q    <= mv_x_d;
            mv_y_q    <= mv_y_d;
        end
    end

    // Current-block store, written one row per LOAD cycle.
    always_ff @(posedge clk) begin
        // NOTE: the block store has no reset; every entry is rewritten by LOAD before SEARCH reads it.
        if (state_q == S_LOAD) begin
            cur_q[addr_q[RW-1:0]] <= pixel_cpr_in;
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign done    = (state_q == S_DONE);
    assign valid   = valid_q;
    assign addr    = addr_q;
    assign amt     = amt_q;
    assign min_sad = min_sad_q;
`ifdef ME_MV_OUT_EN
    assign mv_x    = mv_x_q;
    assign mv_y    = mv_y_q;
`else
    logic unused_mv;
    assign unused_mv = ^{mv_x_q, mv_y_q};
`endif

endmodule

// File: tb/tb_motion_estimator.sv
// Directed bench for motion_estimator: picture RAMs modelled as arrays,
// expected SAD / vector values computed by hand from the planted patterns.
module tb_motion_estimator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  cpr [0:15];
    logic [7:0]  spr [0:16];
    logic        ready, valid, done;
    logic [5:0]  addr, amt;
    logic [15:0] min_sad;
`ifdef ME_MV_OUT_EN
    logic [5:0]  mv_x, mv_y;
`endif

    logic [7:0] cur_img  [0:15][0:15];
    logic [7:0] srch_img [0:47][0:47];
    logic [7:0] garbage;

    int n_checks = 0;
    int n_fail   = 0;

    motion_estimator #(.MACRO_DIM(16), .SEARCH_DIM(48)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pixel_cpr_in (cpr),
        .pixel_spr_in (spr),
        .ready        (ready),
        .valid        (valid),
        .addr         (addr),
        .amt          (amt),
        .min_sad      (min_sad),
`ifdef ME_MV_OUT_EN
        .mv_x         (mv_x),
        .mv_y         (mv_y),
`endif
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Async-read RAM models; columns past the window return the garbage byte.
    always_comb begin
        for (int l = 0; l < 16; l++) cpr[l] = cur_img[addr[3:0]][l];
        for (int l = 0; l < 17; l++) begin
            if (int'(addr) < 48 && int'(amt) + l < 48) spr[l] = srch_img[addr][int'(amt) + l];
            else spr[l] = garbage;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_cur_const(input logic [7:0] v);
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) cur_img[r][c] = v;
    endtask

    task automatic fill_cur_random();
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) cur_img[r][c] = 8'($urandom);
    endtask

    task automatic fill_srch_const(input logic [7:0] v);
        for (int r = 0; r < 48; r++) for (int c = 0; c < 48; c++) srch_img[r][c] = v;
    endtask

    task automatic fill_srch_random();
        for (int r = 0; r < 48; r++) for (int c = 0; c < 48; c++) srch_img[r][c] = 8'($urandom);
    endtask

    task automatic plant_cur(input int dy, input int dx);
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) srch_img[dy + r][dx + c] = cur_img[r][c];
    endtask

    // Runs one search from IDLE and checks result plus handshake timing.
    task automatic run_search(input string tag, input logic [15:0] exp_sad,
                              input logic [5:0] exp_mvx, input logic [5:0] exp_mvy);
        int k;
        int vcnt;
        int dcnt;
        int done_edge;
        bit ready_bad;
        vcnt = 0; dcnt = 0; done_edge = 0; ready_bad = 0; k = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        // k counts edges after the start-sampling edge; the negedge after edge k
        // shows the state it entered, which the following edge (k+1) samples.
        while (k < 9100 && dcnt == 0) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (valid) vcnt++;
            if (ready) ready_bad = 1;
            if (done) begin
                dcnt++;
                done_edge = k + 1;
            end
        end
        check({tag, "_done_seen"}, 32'(dcnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (valid) vcnt++;
        end
        check({tag, "_done_once"}, 32'(dcnt), 32'd1);
        check({tag, "_done_edge"}, 32'(done_edge), 32'd8993);
        check({tag, "_valid_cnt"}, 32'(vcnt), 32'd561);
        check({tag, "_ready_low"}, 32'(ready_bad), 32'd0);
        check({tag, "_ready_back"}, 32'(ready), 32'd1);
        check({tag, "_min_sad"}, 32'(min_sad), 32'(exp_sad));
`ifdef ME_MV_OUT_EN
        check({tag, "_mv_x"}, 32'(mv_x), 32'(exp_mvx));
        check({tag, "_mv_y"}, 32'(mv_y), 32'(exp_mvy));
`else
        if (exp_mvx == 6'h3F && exp_mvy == 6'h3F) $display("note: vector not compiled in");
`endif
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        garbage = 8'h00;
        fill_cur_const(8'h00);
        fill_srch_const(8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_amt", 32'(amt), 32'd0);
        check("rst_min_sad", 32'(min_sad), 32'hFFFF);
        rst = 1'b0;

        // Abort mid-search: a start during SEARCH is ignored, reset clears everything.
        fill_cur_random();
        fill_srch_random();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_ready_low", 32'(ready), 32'd0);
        check("abort_done_low", 32'(done), 32'd0);
        check("abort_sad_moved", 32'(min_sad != 16'hFFFF), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_min_sad", 32'(min_sad), 32'hFFFF);
        check("abort_done", 32'(done), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_addr", 32'(addr), 32'd0);

        // Block copied at dy=10, dx=7 in a random window.
        fill_cur_random();
        fill_srch_random();
        plant_cur(10, 7);
        run_search("copy", 16'd0, 6'd7, 6'd10);

        // Worst case: 256 pixels of 0xFF against 0x00.
        fill_cur_const(8'hFF);
        fill_srch_const(8'h00);
        run_search("max", 16'hFF00, 6'd0, 6'd0);

        // Same, with an attractive byte beyond column 47: lane B at dx=32 must stay ignored.
        garbage = 8'hFF;
        run_search("edge_garbage", 16'hFF00, 6'd0, 6'd0);
        garbage = 8'h00;

        // Two exact matches: earliest in scan order wins.
        fill_cur_random();
        fill_srch_random();
        plant_cur(3, 4);
        plant_cur(20, 1);
        run_search("two_match", 16'd0, 6'd4, 6'd3);

        // Only match is the last candidate (lane A of the final pair), garbage random.
        fill_cur_random();
        fill_srch_random();
        plant_cur(32, 32);
        garbage = 8'h5A;
        run_search("corner", 16'd0, 6'd32, 6'd32);
        garbage = 8'h00;

        // All candidates tie at 256: the first one must be kept.
        fill_cur_const(8'h21);
        fill_srch_const(8'h20);
        run_search("tie", 16'd256, 6'd0, 6'd0);

        // Unique near-match of 256 at odd dx=9, dy=5 (lane B).
        fill_cur_const(8'h21);
        fill_srch_const(8'h00);
        for (int r = 5; r < 21; r++) for (int c = 9; c < 25; c++) srch_img[r][c] = 8'h22;
        run_search("lane_b", 16'd256, 6'd9, 6'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
